ahbl_sram_slave: RTL
====================

// Module: ahbl_sram_slave
// PURPOSE
//  AHB-Lite responder backed by a word-organised on-chip memory. Completes the single
//  NONSEQ/SEQ reads and writes issued by the bus masters and the interconnect. Sits behind
//  the address decoder (HSEL) and inserts a fixed, parameterised number of wait states.
//  Supports byte, halfword and word writes on little-endian byte lanes.
// PARAMETERS
//  ADDR_W       10  word-address bits; memory = 2**ADDR_W x 32b (default 4 KB)
//  WAIT_STATES  0   HREADYOUT-low cycles per data phase, 0..15
// PORTS
//  HCLK       in   1   bus clock; all state updates on rising edge
//  HRESETn    in   1   reset, synchronous, active-low
//  HSEL       in   1   slave select from the decoder
//  HADDR      in   32  byte address; bits [ADDR_W+1:2] index the memory, upper bits alias
//  HTRANS     in   2   transfer type; HTRANS[1]=1 (NONSEQ/SEQ) marks a valid transfer
//  HSIZE      in   3   0=byte, 1=halfword, 2=word
//  HWRITE     in   1   1=write, 0=read
//  HWDATA     in   32  write data, valid during the write data phase
//  HREADY     in   1   bus-wide ready; an address phase is accepted only when it is 1
//  HREADYOUT  out  1   this slave's ready
//  HRDATA     out  32  read data
//  HRESP      out  1   0=OKAY, 1=ERROR
// BEHAVIOUR
//  - Reset (HRESETn=0 at a rising edge): HREADYOUT=1, HRESP=0, HRDATA=0, FSM->IDLE,
//    wait counter=0, pending transfer dropped with no memory write. Memory contents not reset.
//  - Accept: HSEL & HTRANS[1] & HREADY at a rising edge.
//    Latch HADDR[ADDR_W+1:0], HSIZE and HWRITE.
//    IDLE/BUSY transfers, HSEL=0 or HREADY=0: nothing is latched; an OKAY zero-wait response is given.
//  - FSM: IDLE -> (accept, WAIT_STATES>0) WAIT; IDLE -> (accept, WAIT_STATES=0) DATA;
//    WAIT -> (counter reaches WAIT_STATES) DATA; DATA -> (accept) WAIT/DATA, else IDLE.
//  - WAIT: HREADYOUT=0 for exactly WAIT_STATES cycles. No new transfer can be accepted
//    because HREADY is low.
//  - DATA: HREADYOUT=1, HRESP=0. The transfer completes at the edge that ends this cycle.
//  - Write: HWDATA byte lanes are written at the completing edge.
//      Byte: lane HADDR[1:0]. Halfword: lanes {HADDR[1],0} and {HADDR[1],1}. Word: all four.
//      Unwritten lanes are preserved.
//  - Read: HRDATA = mem[latched word addr], combinational during DATA; full 32b word for any
//    HSIZE (the master selects lanes). HRDATA=0 in all other cycles.
//  - Latency: WAIT_STATES=0 gives a one-cycle data phase, so back-to-back pipelined transfers run
//    at one per cycle.
//  - Write followed by a read of the same word: the read returns the new data, because the write
//    commits before the read data phase.
//  - WAIT_STATES>15: clamp to 15.
//  - HSIZE>2: treated as word (see CONFIGURATION).
// CONFIGURATION
//  AHBL_SLAVE_ERR_RESP_EN defined: error checking on the address phase.
//   - Error condition: misaligned access (halfword with HADDR[0]=1, word with HADDR[1:0]!=0)
//     or HSIZE>2.
//   - Response: two-cycle ERROR. ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1.
//     Then IDLE or the next accept.
//   - No wait states are inserted. No memory write. HRDATA=0.
//  Undefined: HRESP is tied 0 and no error checks are made. Misaligned addresses are aligned down
//  (the low bits are ignored for halfword and word); HSIZE>2 acts as word.
// TESTING
//  1 Hold HRESETn=0 for 3 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0 during and after reset.
//  2 WAIT_STATES=0: write 0x41000000<=0x12345678 (HSIZE=2), then read the same address
//    back-to-back -> HRDATA=0x12345678 in the cycle after the read address phase; HREADYOUT
//    never goes low.
//  3 Byte write 0xAB to 0x41000001 -> word reads 0x1234AB78. Then halfword 0xBEEF to
//    0x41000002 -> word reads 0xBEEFAB78.
//  4 WAIT_STATES=2: word read -> HREADYOUT=0 for exactly 2 cycles, then 1 with valid HRDATA.
//    A reset asserted in the 2nd wait cycle of a write -> the target word is unchanged.
//  5 The following do not write memory and leave HREADYOUT=1:
//    - HTRANS=IDLE with HWRITE=1
//    - HSEL=0
//    - HREADY=0 during the address phase
//  6 Word write 0xCAFEF00D to 0x41000002:
//    - Macro defined -> ERR1/ERR2 (HRESP=1 for 2 cycles, HREADYOUT 0 then 1); 0x41000000 unchanged.
//    - Macro undefined -> 0x41000000 reads 0xCAFEF00D.

Source files
------------

// File: rtl/ahbl_sram_slave_if.sv
// AHB-Lite bus bundle between one master/interconnect port and the SRAM responder.
//   master modport: drives the address/control/write-data signals and the bus-wide HREADY,
//                   observes HREADYOUT, HRDATA and HRESP.
//   slave modport : the mirror image, used by ahbl_sram_slave.
interface ahbl_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite responder backed by a 2**ADDR_W x 32-bit word memory.
// Ports:
//   HCLK    - bus clock, all state changes on the rising edge
//   HRESETn - synchronous active-low reset (memory contents are kept)
//   bus     - ahbl_sram_slave_if.slave: HSEL/HADDR/HTRANS/HSIZE/HWRITE/HWDATA/HREADY in,
//             HREADYOUT/HRDATA/HRESP out
// Parameters:
//   ADDR_W      - word-address bits, HADDR[ADDR_W+1:2] index the memory, upper bits alias
//   WAIT_STATES - HREADYOUT-low cycles per data phase, values above 15 act as 15
// Optional feature: define AHBL_SLAVE_ERR_RESP_EN to answer misaligned accesses and HSIZE>2
// with a two-cycle ERROR response. Without it HRESP is tied low, misaligned addresses are
// aligned down and HSIZE>2 behaves as a word access.
module ahbl_sram_slave #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahbl_sram_slave_if.slave bus
);

  localparam int unsigned NumWaits = (WAIT_STATES > 15) ? 15 : WAIT_STATES;
  localparam logic [3:0]  LastWait = (NumWaits == 0) ? 4'd0 : 4'(NumWaits - 1);
  localparam int unsigned Depth    = 2 ** ADDR_W;

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e            state_q, state_d, accept_st;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        size_q;
  logic              write_q;
  logic              hreadyout_q;
  logic              accept, take, addr_err;
  logic [3:0]        lanes;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       mem [Depth];

  // Upper address bits alias and HTRANS[0] only separates NONSEQ from SEQ.
  logic unused_bits;
  assign unused_bits = ^{bus.HADDR[31:ADDR_W+2], bus.HTRANS[0]};

  assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  // HREADY is low in StWait/StErr1, so only these states may start a new transfer.
  assign take   = accept & (state_q inside {StIdle, StData, StErr2});

`ifdef AHBL_SLAVE_ERR_RESP_EN
  always_comb begin
    addr_err = 1'b0;
    if (bus.HSIZE > 3'd2) begin
      addr_err = 1'b1;
    end else if (bus.HSIZE == 3'd2) begin
      addr_err = |bus.HADDR[1:0];
    end else if (bus.HSIZE == 3'd1) begin
      addr_err = bus.HADDR[0];
    end
  end
`else
  assign addr_err = 1'b0;
`endif

  always_comb begin
    if (addr_err) begin
      accept_st = StErr1;
    end else if (NumWaits != 0) begin
      accept_st = StWait;
    end else begin
      accept_st = StData;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle, StData, StErr2: state_d = take ? accept_st : StIdle;
      StWait: begin
        if (wait_cnt_q == LastWait) begin
          state_d    = StData;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      hreadyout_q <= !(state_d inside {StWait, StErr1});
      if (take) begin
        addr_q  <= bus.HADDR[ADDR_W+1:0];
        size_q  <= bus.HSIZE;
        write_q <= bus.HWRITE;
      end
    end
  end

`ifdef AHBL_SLAVE_ERR_RESP_EN
  logic hresp_q;
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      hresp_q <= 1'b0;
    end else begin
      hresp_q <= state_d inside {StErr1, StErr2};
    end
  end
  assign bus.HRESP = hresp_q;
`else
  assign bus.HRESP = 1'b0;
`endif

  // Byte-lane enables of the latched transfer; sizes above halfword write the whole word.
  always_comb begin
    lanes = 4'b1111;
    if (size_q == 3'd0) begin
      lanes = 4'b0001 << addr_q[1:0];
    end else if (size_q == 3'd1) begin
      lanes = addr_q[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign widx = addr_q[ADDR_W+1:2];

  // Writes commit at the edge ending the data phase; a reset on that edge drops them.
  always_ff @(posedge HCLK) begin
    if (HRESETn && (state_q == StData) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) begin
          mem[widx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRDATA    = (HRESETn && (state_q == StData) && !write_q) ? mem[widx] : 32'h0;

endmodule
